// File: rtl/fft_pkg.sv
// Shared types and limits for the FFT result reader.
package fft_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StEmit0,
    StEmit1
  } fft_rd_state_e;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 9;
  localparam int unsigned DefaultNHalf = 512;
  localparam int unsigned ReadLatMin   = 1;
  localparam int unsigned ReadLatMax   = 3;
  localparam int unsigned LatCntW      = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned clamp_read_lat(input int unsigned lat);
    if (lat < ReadLatMin) return ReadLatMin;
    if (lat > ReadLatMax) return ReadLatMax;
    return lat;
  endfunction

endpackage

// File: rtl/fft_result_reader_if.sv
// Output sample stream between the result reader (master) and its consumer (slave).
interface fft_result_reader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              m_valid_o;
  logic              m_ready_i;
  logic              m_last_o;
  logic [DATA_W-1:0] m_re_o;
  logic [DATA_W-1:0] m_im_o;

  modport master (output m_valid_o, m_last_o, m_re_o, m_im_o, input m_ready_i);
  modport slave  (input m_valid_o, m_last_o, m_re_o, m_im_o, output m_ready_i);
endinterface

// File: rtl/fft_addr_gen.sv
// Maps the pair index onto a BRAM address.
// FFT_RESULT_READER_BITREV_EN selects bit-reversed order; natural order otherwise.
module fft_addr_gen #(
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned ADDR_W = 9
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] w_nat;

  assign w_nat = ADDR_W'(idx_i);

`ifdef FFT_RESULT_READER_BITREV_EN
  logic [ADDR_W-1:0] w_rev;

  always_comb begin
    w_rev = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      w_rev[i] = w_nat[ADDR_W-1-i];
    end
  end

  assign addr_o = w_rev;
`else
  assign addr_o = w_nat;
`endif

endmodule

// File: rtl/fft_result_reader.sv
// Unloads a two-bank FFT result BRAM as an interleaved x0/x1 sample stream.
// Define FFT_RESULT_READER_BITREV_EN for bit-reversed read addressing.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned N_HALF   = DefaultNHalf,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                fft_ready_i,
  output logic [ADDR_W-1:0]   x0_addr_o,
  output logic [ADDR_W-1:0]   x1_addr_o,
  input  logic [DATA_W-1:0]   x0_re_i,
  input  logic [DATA_W-1:0]   x0_im_i,
  input  logic [DATA_W-1:0]   x1_re_i,
  input  logic [DATA_W-1:0]   x1_im_i,
  fft_result_reader_if.master m_if,
  output logic                busy_o,
  output logic                done_o,
  output logic                abort_o
);

  localparam int unsigned          IdxW    = idx_width(N_HALF);
  localparam logic [IdxW-1:0]      IdxLast = IdxW'(N_HALF - 1);
  localparam logic [LatCntW-1:0]   LatLast = LatCntW'(clamp_read_lat(READ_LAT) - 1);

  fft_rd_state_e       r_state, w_state_d;
  logic [IdxW-1:0]     r_idx, w_idx_d;
  logic [LatCntW-1:0]  r_lat, w_lat_d;
  logic [DATA_W-1:0]   r_x0_re, r_x0_im, r_x1_re, r_x1_im;
  logic                r_done, w_done_d;
  logic                r_abort, w_abort_d;
  logic                w_capture;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_addr;

  fft_addr_gen #(
    .IDX_W  (IdxW),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .idx_i  (r_idx),
    .addr_o (w_addr)
  );

  assign w_hs = m_if.m_valid_o && m_if.m_ready_i;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_lat_d   = r_lat;
    w_capture = 1'b0;
    w_done_d  = 1'b0;
    w_abort_d = 1'b0;
    // Losing the result banks mid-transfer wins over any handshake this cycle.
    if (r_state != StIdle && !fft_ready_i) begin
      w_state_d = StIdle;
      w_idx_d   = '0;
      w_abort_d = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i && fft_ready_i) begin
            w_state_d = StFetch;
            w_idx_d   = '0;
          end
        end
        StFetch: begin
          w_lat_d   = '0;
          w_state_d = StWait;
        end
        StWait: begin
          if (r_lat == LatLast) begin
            w_capture = 1'b1;
            w_state_d = StEmit0;
          end else begin
            w_lat_d = r_lat + 1'b1;
          end
        end
        StEmit0: begin
          if (w_hs) w_state_d = StEmit1;
        end
        StEmit1: begin
          if (w_hs) begin
            if (r_idx == IdxLast) begin
              w_state_d = StIdle;
              w_idx_d   = '0;
              w_done_d  = 1'b1;
            end else begin
              w_idx_d   = r_idx + 1'b1;
              w_state_d = StFetch;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_lat   <= '0;
      r_x0_re <= '0;
      r_x0_im <= '0;
      r_x1_re <= '0;
      r_x1_im <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_lat   <= w_lat_d;
      r_done  <= w_done_d;
      r_abort <= w_abort_d;
      if (w_capture) begin
        r_x0_re <= x0_re_i;
        r_x0_im <= x0_im_i;
        r_x1_re <= x1_re_i;
        r_x1_im <= x1_im_i;
      end
    end
  end

  assign x0_addr_o      = w_addr;
  assign x1_addr_o      = w_addr;
  assign m_if.m_valid_o = (r_state == StEmit0) || (r_state == StEmit1);
  assign m_if.m_re_o    = (r_state == StEmit1) ? r_x1_re : r_x0_re;
  assign m_if.m_im_o    = (r_state == StEmit1) ? r_x1_im : r_x0_im;
  assign m_if.m_last_o  = (r_state == StEmit1) && (r_idx == IdxLast);
  assign busy_o         = (r_state != StIdle);
  assign done_o         = r_done;
  assign abort_o        = r_abort;

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the sample component width.
REQ-002 SHALL have parameter ADDR_W, default 9, the result BRAM address width.
REQ-003 SHALL have parameter N_HALF, default 512, the number of BRAM words per bank to read.
REQ-004 SHALL have parameter READ_LAT, default 1, the BRAM address-to-data latency in clk cycles (range 1..3).
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  one-cycle request to unload results.
REQ-008 fft_ready_i  in  1  high while the result BRAMs hold a valid FFT and are routed to the output.
REQ-009 x0_addr_o, x1_addr_o  out  ADDR_W  read address driven to both the re and im BRAM of each bank.
REQ-010 x0_re_i, x0_im_i, x1_re_i, x1_im_i  in  DATA_W  BRAM read data.
REQ-011 m_valid_o, m_ready_i  out/in  1  output stream handshake.
REQ-012 m_re_o, m_im_o  out  DATA_W  output sample.
REQ-013 m_last_o  out  1  high with the final sample.
REQ-014 busy_o, done_o, abort_o  out  1  status; done_o and abort_o are one-cycle pulses.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT, EMIT0, EMIT1.
REQ-016 IDLE->FETCH SHALL occur on start_i=1 with fft_ready_i=1; start_i with fft_ready_i=0 SHALL be ignored.
REQ-017 FETCH SHALL drive x0_addr_o=x1_addr_o=addr(idx), clear the latency counter, and go to WAIT.
REQ-018 WAIT SHALL hold the address for READ_LAT cycles, then register all four data inputs into a holding register and go to EMIT0.
REQ-019 EMIT0 SHALL present the x0 pair with m_valid_o=1 and go to EMIT1 on m_valid_o&&m_ready_i.
REQ-020 EMIT1 SHALL present the x1 pair; on handshake it SHALL increment idx, then go to FETCH, or to IDLE with done_o=1 if idx was N_HALF-1.
REQ-021 The output order SHALL be x0[a0], x1[a0], x0[a1], x1[a1], and so on: 2*N_HALF samples in total.
REQ-022 m_last_o SHALL be high only in EMIT1 with idx=N_HALF-1.
REQ-023 Output data SHALL remain stable while m_valid_o=1 and m_ready_i=0, with no limit on stall length.
REQ-024 idx SHALL be a ceil(log2(N_HALF))-bit counter with no wrap beyond N_HALF-1.
REQ-025 start_i while busy SHALL be ignored.
REQ-026 fft_ready_i falling in any non-IDLE state SHALL force IDLE next cycle: m_valid_o=0, abort_o=1, no done_o.
REQ-027 busy_o SHALL be high in every non-IDLE state.

Reset
REQ-028 rst SHALL force IDLE, idx=0, all addresses 0, holding register 0, and m_valid_o, m_last_o, busy_o, done_o, abort_o all 0.
REQ-029 rst mid-transfer SHALL discard the transfer with no done_o or abort_o pulse.

Configuration
REQ-030 With FFT_RESULT_READER_BITREV_EN defined, addr(idx) SHALL be idx with its ADDR_W bits reversed.
REQ-031 Without FFT_RESULT_READER_BITREV_EN, addr(idx)=idx (natural order).

Structure
REQ-032 The FSM state enum, the READ_LAT limit and the default widths SHALL reside in package fft_pkg.
REQ-033 Address generation, including the bit reversal, SHALL be sub-module fft_addr_gen.

Verification
REQ-034 Bench: N_HALF=4, READ_LAT=1, m_ready_i=1, BRAM word a = {re=a, im=0x100+a} for the x0 bank and {re=0x10+a, im=0x110+a} for the x1 bank. Required response: 8 samples 0,0x10,1,0x11,...; m_last_o on the 8th; done_o one cycle after it.
REQ-035 Bench: as REQ-034 with m_ready_i low for 5 cycles during EMIT0. Required response: m_re_o and m_im_o held constant, no sample lost or duplicated.
REQ-036 Bench: fft_ready_i dropped after the 3rd sample. Required response: abort_o pulse, m_valid_o=0 next cycle, no done_o; a later start_i restarts from idx=0.
REQ-037 Bench: rst asserted in WAIT. Required response: all outputs at reset values next cycle.
REQ-038 Bench: BITREV_EN defined, ADDR_W=3, N_HALF=8. Required response: address sequence 0,4,2,6,1,5,3,7.
REQ-039 Bench: start_i with fft_ready_i=0, and start_i while busy. Required response: no state change in either case.
